// File: rtl/bram_ctrl_pkg.sv
// Shared types and sizing for the block-RAM port initiator and its response buffer.
package bram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int RSP_DEPTH = 2;

    // Bits needed to count 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int OCC_W = occ_width(RSP_DEPTH);

endpackage

// File: rtl/bram_rsp_fifo2.sv
// Two-entry in-order response buffer; push and pop may coincide at any occupancy.
module bram_rsp_fifo2
    import bram_ctrl_pkg::*;
#(
    parameter int DWIDTH = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DWIDTH-1:0] push_data_i,
    input  logic              pop_i,
    output logic [OCC_W-1:0]  occ_o,
    output logic [DWIDTH-1:0] head_o
);

    logic [DWIDTH-1:0] mem_q [RSP_DEPTH];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;

    always_comb begin
        occ_d = occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
    end

    // When full, a simultaneous push lands in the slot being popped this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/bram_port_initiator.sv
// Drives one port of an inferred dual-port RAM from a command stream, returns read
// data on a response stream, and zero-sweeps the array after reset or on request.
module bram_port_initiator
    import bram_ctrl_pkg::*;
#(
    parameter int AWIDTH         = 10,
    parameter int DWIDTH         = 36,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_start,
    output logic              busy,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              mem_rce,
    output logic [AWIDTH-1:0] mem_ra,
    input  logic [DWIDTH-1:0] mem_rq,
    output logic              mem_wce,
    output logic [AWIDTH-1:0] mem_wa,
    output logic [DWIDTH-1:0] mem_wd,
    output logic [1:0]        dbg_state
);

    // Handshakes: a beat transfers on a rising clk edge where valid & ready are both 1;
    // valid, once raised, holds with stable payload until the transfer; ready may
    // depend combinationally on the opposite side (cmd_ready follows rsp_ready).

    state_t            state_q;
    logic [AWIDTH-1:0] clr_cnt_q;
    logic              inflight_q;
    logic              clear_pend_q;

    logic [OCC_W-1:0]  occ;
    logic              run_open;
    logic              rsp_pop;
    logic [OCC_W:0]    committed;
    logic              credit_ok;
    logic              wr_acc;
    logic              rd_acc;

    assign run_open = (state_q == ST_RUN) && !clear_pend_q;
    assign rsp_valid = (occ != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;

    // Reads hold a buffer slot from acceptance until the consumer takes the data.
    assign committed = {1'b0, occ} + (OCC_W + 1)'(inflight_q);
    assign credit_ok = (committed - (OCC_W + 1)'(rsp_pop)) < (OCC_W + 1)'(RSP_DEPTH);

    assign cmd_ready = run_open && (cmd_we || credit_ok);
    assign wr_acc    = cmd_valid && cmd_ready && cmd_we;
    assign rd_acc    = cmd_valid && cmd_ready && !cmd_we;
    assign busy      = (state_q != ST_RUN) || clear_pend_q;
    assign dbg_state = state_q;

    always_comb begin
        mem_rce = 1'b0;
        mem_ra  = '0;
        mem_wce = 1'b0;
        mem_wa  = '0;
        mem_wd  = '0;
        if (state_q == ST_CLEAR) begin
            mem_wce = 1'b1;
            mem_wa  = clr_cnt_q;
        end else if (wr_acc) begin
            mem_wce = 1'b1;
            mem_wa  = cmd_addr;
            mem_wd  = cmd_wdata;
        end
        if (rd_acc) begin
            mem_rce = 1'b1;
            mem_ra  = cmd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            clr_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            clear_pend_q <= 1'b0;
        end else begin
            inflight_q <= rd_acc;
            case (state_q)
                ST_INIT: state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + AWIDTH'(1);
                    if (clr_cnt_q == '1) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    // The sweep waits for the last issued read so its data is not lost.
                    if (clear_pend_q) begin
                        if (!inflight_q) begin
                            clear_pend_q <= 1'b0;
                            state_q      <= ST_CLEAR;
                        end
                    end else if (clear_start) begin
                        clear_pend_q <= 1'b1;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    bram_rsp_fifo2 #(
        .DWIDTH(DWIDTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (mem_rq),
        .pop_i       (rsp_pop),
        .occ_o       (occ),
        .head_o      (rsp_rdata)
    );

endmodule

// File: tb/tb_bram_port_initiator.sv
// Bench for bram_port_initiator (AWIDTH=4) with a behavioural RAM and a reference
// model of memory contents and outstanding read responses.
module tb_bram_port_initiator;

    localparam int AW    = 4;
    localparam int DW    = 36;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_start;
    logic          busy;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          mem_rce;
    logic [AW-1:0] mem_ra;
    logic [DW-1:0] mem_rq;
    logic          mem_wce;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic [1:0]    dbg_state;

    bram_port_initiator #(
        .AWIDTH(AW), .DWIDTH(DW), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .busy(busy),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_rce(mem_rce), .mem_ra(mem_ra), .mem_rq(mem_rq),
        .mem_wce(mem_wce), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / RAM ----------------
    always #5 clk = ~clk;

    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_wce) ram[mem_wa] <= mem_wd;
        if (mem_rce) mem_rq <= ram[mem_ra];
    end

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            pop_cyc [$];
    bit            model_run;
    int            cyc;
    int            n_tests;
    int            n_fail;

    logic          s_cmd_ready, s_rsp_valid, s_busy, s_acc, s_pop;
    logic          s_mem_wce, s_mem_rce;
    logic [AW-1:0] s_mem_wa;
    logic [DW-1:0] s_mem_wd, s_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample outputs mid-cycle, score it, advance to the next negedge.
    task automatic tick();
        logic [DW-1:0] e;
        int            outstanding;
        #1;
        s_cmd_ready = cmd_ready;
        s_rsp_valid = rsp_valid;
        s_busy      = busy;
        s_rdata     = rsp_rdata;
        s_mem_wce   = mem_wce;
        s_mem_rce   = mem_rce;
        s_mem_wa    = mem_wa;
        s_mem_wd    = mem_wd;
        s_acc       = cmd_valid && s_cmd_ready;
        s_pop       = s_rsp_valid && rsp_ready;
        outstanding = exp_q.size();
        chk("cmd_ready", s_cmd_ready,
            model_run && (cmd_we || (outstanding - int'(s_pop)) < 2));
        if (s_acc && cmd_we) begin
            chk("wr_strobe", {s_mem_wce, s_mem_rce}, 2'b10);
            chk("wr_addr", s_mem_wa, cmd_addr);
            chk("wr_data", s_mem_wd, cmd_wdata);
            ref_mem[cmd_addr] = cmd_wdata;
        end else if (s_acc) begin
            chk("rd_strobe", {s_mem_rce, mem_ra}, {1'b1, cmd_addr});
            exp_q.push_back(ref_mem[cmd_addr]);
        end
        if (s_pop) begin
            if (exp_q.size() == 0) begin
                chk("rsp_spurious", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", s_rdata, e);
                pop_cyc.push_back(cyc);
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_empty", exp_q.size(), 0);
        tick();
        chk("no_extra_rsp", s_rsp_valid, 0);
    endtask

    // Expects a full zero sweep starting this cycle; optionally pokes clear_start mid-sweep.
    task automatic expect_clear(input bit poke);
        cmd_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            clear_start = poke && (i == 5);
            tick();
            chk("clr_wce", s_mem_wce, 1);
            chk("clr_wa", s_mem_wa, i);
            chk("clr_wd", s_mem_wd, 0);
            chk("clr_busy", s_busy, 1);
        end
        clear_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        model_run = 1'b1;
        tick();
        chk("run_busy", s_busy, 0);
        chk("run_wce", s_mem_wce, 0);
    endtask

    task automatic check_in_reset(input string tag);
        #1;
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_wce"}, mem_wce, 0);
        chk({tag, "_rce"}, mem_rce, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_wa_wd"}, {mem_wa, mem_wd}, 0);
        chk({tag, "_rdata"}, rsp_rdata, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] r64;
        logic [DW-1:0] v5;
        int n_acc;
        n_tests = 0; n_fail = 0; cyc = 0; model_run = 1'b0;
        rst_n = 1'b0; clear_start = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b1;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            r64 = {$urandom(), $urandom()};
            ram[i] = r64[DW-1:0] | 36'h1;
            ref_mem[i] = 'x;
        end

        // Reset and automatic sweep.
        @(negedge clk);
        check_in_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("init_busy", s_busy, 1);
        chk("init_wce", s_mem_wce, 0);
        expect_clear(1'b0);

        // Write 3, read 3: data visible exactly two cycles after acceptance.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'd3; cmd_wdata = 36'h123456789;
        tick();
        chk("w3_acc", s_acc, 1);
        cmd_we = 1'b0; rsp_ready = 1'b1;
        tick();
        chk("r3_acc", s_acc, 1);
        cmd_valid = 1'b0;
        tick();
        chk("r3_lat1", s_rsp_valid, 0);
        tick();
        chk("r3_lat2", s_rsp_valid, 1);
        chk("r3_data", s_rdata, 36'h123456789);
        drain();

        // Fill with random data, then back-to-back reads of 0..7.
        for (int i = 0; i < DEPTH; i++) begin
            r64 = {$urandom(), $urandom()};
            cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = AW'(i); cmd_wdata = r64[DW-1:0];
            tick();
        end
        pop_cyc.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = AW'(i);
            tick();
            chk("b2b_ready", s_cmd_ready, 1);
        end
        drain();
        chk("b2b_count", pop_cyc.size(), 8);
        if (pop_cyc.size() == 8) chk("b2b_consecutive", pop_cyc[7] - pop_cyc[0], 7);

        // Backpressure: only two reads fit.
        rsp_ready = 1'b0; n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = AW'($urandom_range(0, DEPTH - 1));
            tick();
            if (s_acc) n_acc++;
        end
        chk("bp_accepted", n_acc, 2);
        chk("bp_ready_low", s_cmd_ready, 0);
        drain();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            r64 = {$urandom(), $urandom()};
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_we    = ($urandom_range(0, 2) == 0);
            cmd_addr  = AW'($urandom_range(0, DEPTH - 1));
            cmd_wdata = r64[DW-1:0];
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Clear requested with a read in flight.
        r64 = {$urandom(), $urandom()};
        v5 = r64[DW-1:0] | 36'h1;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'd5; cmd_wdata = v5;
        tick();
        cmd_we = 1'b0; clear_start = 1'b1; rsp_ready = 1'b1;
        tick();
        chk("clr_rd_acc", s_acc, 1);
        model_run = 1'b0;
        clear_start = 1'b0;
        tick();
        chk("pend_busy", s_busy, 1);
        chk("pend_no_rd", s_mem_rce, 0);
        chk("pend_no_wce", s_mem_wce, 0);
        cmd_valid = 1'b0;
        tick();
        chk("pend_wait_wce", s_mem_wce, 0);
        chk("clr_rsp_done", exp_q.size(), 0);
        expect_clear(1'b1);
        chk("clr_ignored_busy", s_busy, 0);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'd5;
        tick();
        chk("r5_acc", s_acc, 1);
        drain();

        // Reset mid-sweep with two responses buffered.
        rsp_ready = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = AW'(i);
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("buf2_valid", s_rsp_valid, 1);
        clear_start = 1'b1;
        tick();
        model_run = 1'b0;
        clear_start = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_clr_wa", {s_mem_wce, s_mem_wa}, {1'b1, AW'(i)});
            chk("mid_clr_hold", s_rsp_valid, 1);
        end
        rst_n = 1'b0;
        check_in_reset("midrst");
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("reinit_busy", s_busy, 1);
        chk("reinit_wce", s_mem_wce, 0);
        expect_clear(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
